// File: rtl/bit_population_word_assembler.sv
// bit_population_word_assembler
// Packs a stream of IN_WIDTH-bit beats into one OUT_WIDTH-bit word for the
// bit population counter. Short packets (closed by data_last_i) are
// zero-padded, so padding never adds to the population count. The finished
// word sits in a dedicated output register, which lets the next word start
// on the very next cycle with no backpressure.

module bit_population_word_assembler #(
    parameter  int IN_WIDTH  = 16,
    parameter  int OUT_WIDTH = 1024,
    localparam int BEATS     = OUT_WIDTH / IN_WIDTH,
    localparam int CNT_W     = $clog2(BEATS + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [IN_WIDTH-1:0]  data_i,
    input  logic                 data_val_i,
    input  logic                 data_last_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 data_val_o,
    output logic [CNT_W-1:0]     beats_o
);

    // Slot index of the final beat of a full word.
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);

    // Writes one beat into slot idx of a word and leaves every other slot
    // untouched. Beat 0 lands at the LSBs.
    function automatic logic [OUT_WIDTH-1:0] place_beat(
        input logic [OUT_WIDTH-1:0] word,
        input logic [IN_WIDTH-1:0]  beat,
        input logic [CNT_W-1:0]     idx
    );
        logic [OUT_WIDTH-1:0] result;
        result = word;
        result[int'(idx) * IN_WIDTH +: IN_WIDTH] = beat;
        return result;
    endfunction

    logic [OUT_WIDTH-1:0] acc_r;     // partially assembled word
    logic [CNT_W-1:0]     cnt_r;     // next free slot
    logic [OUT_WIDTH-1:0] merged_s;  // accumulator with this cycle's beat
    logic                 close_s;   // this cycle's beat finishes a word
    logic [CNT_W-1:0]     cnt_inc_s; // slot count including this beat

    // Merge the incoming beat and decide whether it closes the word.
    // The accumulator is cleared on every close, so slots above the
    // closing beat are already zero.
    always_comb begin
        merged_s  = place_beat(acc_r, data_i, cnt_r);
        cnt_inc_s = cnt_r + CNT_W'(1);
        if (data_val_i) begin
            close_s = (cnt_r == LAST_SLOT) || data_last_i;
        end else begin
            close_s = 1'b0;
        end
    end

    // Beat accumulator and slot counter; both restart on a close so the
    // next word can begin in the following cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_r <= {OUT_WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (data_val_i) begin
            if (close_s) begin
                acc_r <= {OUT_WIDTH{1'b0}};
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                acc_r <= merged_s;
                cnt_r <= cnt_inc_s;
            end
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Output register: captures the completed word, strobes valid for one
    // cycle and holds data and beat count until the next close.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o     <= {OUT_WIDTH{1'b0}};
            beats_o    <= {CNT_W{1'b0}};
            data_val_o <= 1'b0;
        end else if (close_s) begin
            data_o     <= merged_s;
            beats_o    <= cnt_inc_s;
            data_val_o <= 1'b1;
        end else begin
            data_o     <= data_o;
            beats_o    <= beats_o;
            data_val_o <= 1'b0;
        end
    end

endmodule
